wb_stage_multi: RTL and testbench
=================================

Name: wb_stage_multi

Overview:
- Parametrised multi-lane write-back stage for the pipelined MIPS core; next generation of the single-lane write-back register/mux stage.
- Registers NLANES retiring results from MEM/WB and selects the write data per lane (ALU, load, jal link, lui).
- Adds what the single-lane stage lacks: sub-word load extension, flush, $zero write suppression, same-cycle write-conflict resolution, and a retire counter.
- Drives register-file write ports and WB-stage forwarding.

Parameters:
- NLANES, 2, number of parallel retire lanes (1..4)
- DW, 32, data word width
- RW, 5, register address width
- CNTW, 32, retire counter width

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- wben  in  1  stage advance enable
- flush  in  1  insert bubble into all lanes
- in_valid  in  NLANES  lane holds a real instruction
- regWr  in  NLANES  lane writes register file
- regDst  in  NLANES*RW  destination register per lane
- regSel  in  NLANES*2  source select: 0 ALU, 1 nPC (jal), 2 lui, 3 load
- ldMode  in  NLANES*3  0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as lw
- ALUOut, nPC, lui, dmemload  in  NLANES*DW each  candidate results; ALUOut[1:0] is the load byte offset
- instru  in  NLANES*DW  instruction word, for trace
- WEN  out  NLANES  register-file write enable per lane
- wsel  out  NLANES*RW  write address per lane
- wdat  out  NLANES*DW  write data per lane
- instru_next  out  NLANES*DW  registered instruction, for trace
- fwd_valid  out  NLANES  equals WEN; forwarding qualifier
- retired  out  CNTW  count of retired valid lanes

Behaviour:
- All sequential logic is on posedge CLK.
- Priority order: RST, then flush, then wben, then hold.
- RST clears every stage register:
  - valid=0, regSel=0, ldMode=0, data=0, wsel=0, instru_next=0, retired=0.
  - Result: WEN=0 and wdat=0 in the cycle after reset.
- flush=1 clears valid and the registered regWr in all lanes and sets instru_next=0. Data registers may hold. retired does not count the cycle.
- wben=1 with flush=0 captures all lane inputs.
- wben=0 with flush=0 holds all registers. WEN stays asserted if already set; rewriting the same value is harmless.
- Latency: one cycle from input to WEN/wsel. wdat is combinational from the registered values.
- WEN[i] = reg_valid[i] & reg_regWr[i] & (reg_wsel[i]!=0). Writes to $zero are always suppressed.
- Conflict rule: if WEN[i] and WEN[j] with j>i target the same wsel, lane j (younger) wins and WEN[i] is forced 0.
- Load extension applies when regSel=3. Big-endian; off = registered ALUOut[1:0].
  - lb/lbu: byte = dmemload[31-8*off -: 8]; lb sign-extends, lbu zero-extends.
  - lh/lhu: half = off[1] ? dmemload[15:0] : dmemload[31:16]; off[0] is ignored.
  - lw: pass dmemload through unchanged.
- retired increments by popcount(valid in the next state) on every wben=1, flush=0 cycle, i.e. the lanes being captured. It wraps modulo 2^CNTW.
- Lanes are independent except for the conflict rule.

Decomposition:
- Shared package wb_pkg:
  - word_t
  - regsel_t enum: SEL_ALU, SEL_NPC, SEL_LUI, SEL_LOAD
  - ldmode_t enum: LD_W, LD_B, LD_BU, LD_H, LD_HU
  - regaddr_t
- Sub-module load_extend:
  - Purely combinational.
  - Inputs: dmemload, ldMode, off. Output: the extended word.
  - Instantiated once per lane.

Test Plan:
- RST=1 for 2 cycles with random inputs → WEN=0, wdat=0, retired=0, instru_next=0.
- Lane0 valid, regWr, regDst=8, regSel=0, ALUOut=0x1234_5678, wben=1 → next cycle WEN[0]=1, wsel[0]=8, wdat[0]=0x1234_5678, retired=1.
- dmemload=0x80FF_7F01, regSel=3, ldMode=lb with off=0 → wdat=0xFFFF_FF80. Same data:
  - lbu, off=1 → 0x0000_00FF
  - lh, off=2 → 0x0000_7F01
  - lhu, off=0 → 0x0000_80FF
- Both lanes valid, regWr, regDst=5; lane0 ALUOut=1, lane1 lui=0xABCD_0000, regSel=2 → WEN=2'b10, wdat[1]=0xABCD_0000.
- regDst=0 with regWr=1 → WEN=0. Then flush=1 together with wben=1 → WEN=0, instru_next=0, retired unchanged.
- retired preloaded near wrap (CNTW=4, 15 retires then 2 lanes) → retired=1. wben=0 for 3 cycles → all outputs hold.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the multi-lane write-back stage: data words, register
// addresses, result-source select and load-width encodings.
package wb_pkg;

  localparam int WORD_W = 32;
  localparam int RADDR_W = 5;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [RADDR_W-1:0] regaddr_t;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_NPC  = 2'd1,
    SEL_LUI  = 2'd2,
    SEL_LOAD = 2'd3
  } regsel_t;

  // Codes 5..7 are not listed here; the extender treats them as a full word.
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ldmode_t;

endpackage

// File: rtl/wb_stage_multi_if.sv
// Bundle of MEM/WB inputs and register-file / forwarding outputs for the
// multi-lane write-back stage; lanes are packed side by side, lane 0 in the LSBs.
interface wb_stage_multi_if #(
  parameter int NLANES = 2,
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int CNTW   = 32
);

  logic                   wben;
  logic                   flush;
  logic [NLANES-1:0]      in_valid;
  logic [NLANES-1:0]      regWr;
  logic [NLANES*RW-1:0]   regDst;
  logic [NLANES*2-1:0]    regSel;
  logic [NLANES*3-1:0]    ldMode;
  logic [NLANES*DW-1:0]   ALUOut;
  logic [NLANES*DW-1:0]   nPC;
  logic [NLANES*DW-1:0]   lui;
  logic [NLANES*DW-1:0]   dmemload;
  logic [NLANES*DW-1:0]   instru;

  logic [NLANES-1:0]      WEN;
  logic [NLANES*RW-1:0]   wsel;
  logic [NLANES*DW-1:0]   wdat;
  logic [NLANES*DW-1:0]   instru_next;
  logic [NLANES-1:0]      fwd_valid;
  logic [CNTW-1:0]        retired;

  modport master (
    output wben, flush, in_valid, regWr, regDst, regSel, ldMode,
           ALUOut, nPC, lui, dmemload, instru,
    input  WEN, wsel, wdat, instru_next, fwd_valid, retired
  );

  modport slave (
    input  wben, flush, in_valid, regWr, regDst, regSel, ldMode,
           ALUOut, nPC, lui, dmemload, instru,
    output WEN, wsel, wdat, instru_next, fwd_valid, retired
  );

endinterface

// File: rtl/wb_stage_multi_load_extend.sv
// Big-endian sub-word load extraction and sign/zero extension for one lane.
module load_extend
  import wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] dmemload,
  input  logic [2:0]    ldMode,
  input  logic [1:0]    off,
  output logic [DW-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte offset 0 is the most significant byte of the word.
  always_comb begin
    byte_sel = dmemload[DW-1 -: 8];
    case (off)
      2'd0:    byte_sel = dmemload[DW-1  -: 8];
      2'd1:    byte_sel = dmemload[DW-9  -: 8];
      2'd2:    byte_sel = dmemload[DW-17 -: 8];
      default: byte_sel = dmemload[DW-25 -: 8];
    endcase
    half_sel = off[1] ? dmemload[DW-17 -: 16] : dmemload[DW-1 -: 16];
  end

  always_comb begin
    ext = dmemload;
    case (ldMode)
      LD_B:    ext = {{(DW-8){byte_sel[7]}}, byte_sel};
      LD_BU:   ext = {{(DW-8){1'b0}}, byte_sel};
      LD_H:    ext = {{(DW-16){half_sel[15]}}, half_sel};
      LD_HU:   ext = {{(DW-16){1'b0}}, half_sel};
      default: ext = dmemload;
    endcase
  end

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane MEM/WB register and write-back select: per-lane result mux,
// $zero suppression, younger-lane-wins write conflicts and a retire counter.
module wb_stage_multi
  import wb_pkg::*;
#(
  parameter int NLANES = 2,
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int CNTW   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  wb_stage_multi_if.slave  bus
);

  logic [NLANES-1:0]         reg_valid;
  logic [NLANES-1:0]         reg_regwr;
  logic [NLANES-1:0][RW-1:0] reg_wsel;
  logic [NLANES-1:0][1:0]    reg_sel;
  logic [NLANES-1:0][2:0]    reg_ldmode;
  logic [NLANES-1:0][DW-1:0] reg_alu;
  logic [NLANES-1:0][DW-1:0] reg_npc;
  logic [NLANES-1:0][DW-1:0] reg_lui;
  logic [NLANES-1:0][DW-1:0] reg_load;
  logic [NLANES-1:0][DW-1:0] reg_instru;
  logic [CNTW-1:0]           retired_q;

  logic [CNTW-1:0]           capture_cnt;
  logic [NLANES-1:0]         raw_wen;
  logic [NLANES-1:0]         wen;
  logic [NLANES-1:0][DW-1:0] ext_word;
  logic [NLANES-1:0][DW-1:0] wdat_lane;

  always_comb begin
    capture_cnt = '0;
    for (int i = 0; i < NLANES; i++) begin
      capture_cnt = capture_cnt + CNTW'(bus.in_valid[i]);
    end
  end

  // Flush only kills the write qualifiers and trace; data registers keep their value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      reg_valid  <= '0;
      reg_regwr  <= '0;
      reg_wsel   <= '0;
      reg_sel    <= '0;
      reg_ldmode <= '0;
      reg_alu    <= '0;
      reg_npc    <= '0;
      reg_lui    <= '0;
      reg_load   <= '0;
      reg_instru <= '0;
      retired_q  <= '0;
    end else if (bus.flush) begin
      reg_valid  <= '0;
      reg_regwr  <= '0;
      reg_instru <= '0;
    end else if (bus.wben) begin
      reg_valid  <= bus.in_valid;
      reg_regwr  <= bus.regWr;
      reg_wsel   <= bus.regDst;
      reg_sel    <= bus.regSel;
      reg_ldmode <= bus.ldMode;
      reg_alu    <= bus.ALUOut;
      reg_npc    <= bus.nPC;
      reg_lui    <= bus.lui;
      reg_load   <= bus.dmemload;
      reg_instru <= bus.instru;
      retired_q  <= retired_q + capture_cnt;
    end
  end

  // A lane loses its write when any younger lane writes the same register.
  always_comb begin
    raw_wen = '0;
    wen     = '0;
    for (int i = 0; i < NLANES; i++) begin
      raw_wen[i] = reg_valid[i] & reg_regwr[i] & (reg_wsel[i] != '0);
    end
    for (int i = 0; i < NLANES; i++) begin
      wen[i] = raw_wen[i];
      for (int j = i + 1; j < NLANES; j++) begin
        if (raw_wen[j] && (reg_wsel[j] == reg_wsel[i])) begin
          wen[i] = 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    load_extend #(.DW(DW)) u_load_extend (
      .dmemload (reg_load[g]),
      .ldMode   (reg_ldmode[g]),
      .off      (reg_alu[g][1:0]),
      .ext      (ext_word[g])
    );
  end

  always_comb begin
    wdat_lane = '0;
    for (int i = 0; i < NLANES; i++) begin
      case (regsel_t'(reg_sel[i]))
        SEL_ALU:  wdat_lane[i] = reg_alu[i];
        SEL_NPC:  wdat_lane[i] = reg_npc[i];
        SEL_LUI:  wdat_lane[i] = reg_lui[i];
        SEL_LOAD: wdat_lane[i] = ext_word[i];
        default:  wdat_lane[i] = reg_alu[i];
      endcase
    end
  end

  assign bus.WEN         = wen;
  assign bus.fwd_valid   = wen;
  assign bus.wsel        = reg_wsel;
  assign bus.wdat        = wdat_lane;
  assign bus.instru_next = reg_instru;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed, table-driven bench for wb_stage_multi with two lanes and a 4-bit
// retire counter so that counter wrap is reachable in a short run.
module tb_wb_stage_multi;
  import wb_pkg::*;

  localparam int NL = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  typedef struct {
    logic        valid;
    logic        regwr;
    logic [4:0]  dst;
    logic [1:0]  sel;
    logic [2:0]  ld;
    logic [31:0] alu;
    logic [31:0] npc;
    logic [31:0] lui;
    logic [31:0] mem;
    logic [31:0] exp_wdat;
  } lane_t;

  typedef struct {
    lane_t      lane [NL];
    logic [1:0] exp_wen;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;
  logic [CW-1:0] expRetired;
  vec_t vecs [9];
  vec_t tmp;

  always #5 CLK = ~CLK;

  wb_stage_multi_if #(.NLANES(NL), .DW(DW), .RW(RW), .CNTW(CW)) bus ();

  wb_stage_multi #(.NLANES(NL), .DW(DW), .RW(RW), .CNTW(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  function automatic lane_t mkLane(input logic v, input logic w, input logic [4:0] d,
                                   input logic [1:0] s, input logic [2:0] l,
                                   input logic [31:0] a, input logic [31:0] n,
                                   input logic [31:0] u, input logic [31:0] m,
                                   input logic [31:0] e);
    lane_t r;
    r.valid = v; r.regwr = w; r.dst = d; r.sel = s; r.ld = l;
    r.alu = a; r.npc = n; r.lui = u; r.mem = m; r.exp_wdat = e;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int k, input logic wb, input logic fl);
    bus.wben  = wb;
    bus.flush = fl;
    for (int i = 0; i < NL; i++) begin
      bus.in_valid[i]           = v.lane[i].valid;
      bus.regWr[i]              = v.lane[i].regwr;
      bus.regDst[i*RW +: RW]    = v.lane[i].dst;
      bus.regSel[i*2 +: 2]      = v.lane[i].sel;
      bus.ldMode[i*3 +: 3]      = v.lane[i].ld;
      bus.ALUOut[i*DW +: DW]    = v.lane[i].alu;
      bus.nPC[i*DW +: DW]       = v.lane[i].npc;
      bus.lui[i*DW +: DW]       = v.lane[i].lui;
      bus.dmemload[i*DW +: DW]  = v.lane[i].mem;
      bus.instru[i*DW +: DW]    = 32'hC0DE_0000 + 32'(k * 2 + i);
    end
  endtask

  task automatic checkVec(input vec_t v, input int k);
    checkOutput($sformatf("v%0d_wen", k), 32'(bus.WEN), 32'(v.exp_wen));
    checkOutput($sformatf("v%0d_fwd", k), 32'(bus.fwd_valid), 32'(v.exp_wen));
    checkOutput($sformatf("v%0d_retired", k), 32'(bus.retired), 32'(expRetired));
    for (int i = 0; i < NL; i++) begin
      checkOutput($sformatf("v%0d_wsel%0d", k, i), 32'(bus.wsel[i*RW +: RW]), 32'(v.lane[i].dst));
      checkOutput($sformatf("v%0d_wdat%0d", k, i), bus.wdat[i*DW +: DW], v.lane[i].exp_wdat);
      checkOutput($sformatf("v%0d_instru%0d", k, i), bus.instru_next[i*DW +: DW],
                  32'hC0DE_0000 + 32'(k * 2 + i));
    end
  endtask

  task automatic randomInputs(input logic wb, input logic fl);
    bus.wben     = wb;
    bus.flush    = fl;
    bus.in_valid = NL'($urandom);
    bus.regWr    = NL'($urandom);
    bus.regDst   = (NL*RW)'($urandom);
    bus.regSel   = (NL*2)'($urandom);
    bus.ldMode   = (NL*3)'($urandom);
    bus.ALUOut   = {$urandom, $urandom};
    bus.nPC      = {$urandom, $urandom};
    bus.lui      = {$urandom, $urandom};
    bus.dmemload = {$urandom, $urandom};
    bus.instru   = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0].lane[0] = mkLane(1, 1, 5'd8,  2'd0, 3'd0, 32'h1234_5678, 0, 0, 0, 32'h1234_5678);
    vecs[0].lane[1] = mkLane(0, 0, 5'd0,  2'd0, 3'd0, 0, 0, 0, 0, 0);
    vecs[0].exp_wen = 2'b01;
    vecs[1].lane[0] = mkLane(1, 1, 5'd9,  2'd3, 3'd1, 32'h100, 0, 0, 32'h80FF_7F01, 32'hFFFF_FF80);
    vecs[1].lane[1] = mkLane(1, 1, 5'd10, 2'd3, 3'd2, 32'h101, 0, 0, 32'h80FF_7F01, 32'h0000_00FF);
    vecs[1].exp_wen = 2'b11;
    vecs[2].lane[0] = mkLane(1, 1, 5'd11, 2'd3, 3'd3, 32'h102, 0, 0, 32'h80FF_7F01, 32'h0000_7F01);
    vecs[2].lane[1] = mkLane(1, 1, 5'd12, 2'd3, 3'd4, 32'h200, 0, 0, 32'h80FF_7F01, 32'h0000_80FF);
    vecs[2].exp_wen = 2'b11;
    vecs[3].lane[0] = mkLane(1, 1, 5'd13, 2'd3, 3'd1, 32'h3, 0, 0, 32'h80FF_7F01, 32'h0000_0001);
    vecs[3].lane[1] = mkLane(1, 1, 5'd14, 2'd3, 3'd3, 32'h3, 0, 0, 32'h1234_F00D, 32'hFFFF_F00D);
    vecs[3].exp_wen = 2'b11;
    vecs[4].lane[0] = mkLane(1, 1, 5'd15, 2'd3, 3'd7, 32'h3, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[4].lane[1] = mkLane(1, 1, 5'd31, 2'd1, 3'd0, 0, 32'h0040_0008, 0, 0, 32'h0040_0008);
    vecs[4].exp_wen = 2'b11;
    vecs[5].lane[0] = mkLane(1, 1, 5'd5,  2'd0, 3'd0, 32'h1, 0, 0, 0, 32'h1);
    vecs[5].lane[1] = mkLane(1, 1, 5'd5,  2'd2, 3'd0, 0, 0, 32'hABCD_0000, 0, 32'hABCD_0000);
    vecs[5].exp_wen = 2'b10;
    vecs[6].lane[0] = mkLane(1, 1, 5'd0,  2'd0, 3'd0, 32'h55, 0, 0, 0, 32'h55);
    vecs[6].lane[1] = mkLane(1, 0, 5'd3,  2'd0, 3'd0, 32'h66, 0, 0, 0, 32'h66);
    vecs[6].exp_wen = 2'b00;
    vecs[7].lane[0] = mkLane(0, 1, 5'd4,  2'd0, 3'd0, 32'h11, 0, 0, 0, 32'h11);
    vecs[7].lane[1] = mkLane(1, 1, 5'd4,  2'd0, 3'd0, 32'h77, 0, 0, 0, 32'h77);
    vecs[7].exp_wen = 2'b10;
    vecs[8].lane[0] = mkLane(1, 1, 5'd1,  2'd3, 3'd1, 32'h1, 0, 0, 32'h80FF_7F01, 32'hFFFF_FFFF);
    vecs[8].lane[1] = mkLane(1, 1, 5'd2,  2'd3, 3'd2, 32'h2, 0, 0, 32'h80FF_7F01, 32'h0000_007F);
    vecs[8].exp_wen = 2'b11;

    $display("[TB] reset with random inputs");
    RST = 1'b1;
    randomInputs(1'b1, 1'b0);
    tick();
    randomInputs(1'b1, 1'b1);
    tick();
    checkOutput("rst_wen", 32'(bus.WEN), 32'h0);
    checkOutput("rst_fwd", 32'(bus.fwd_valid), 32'h0);
    checkOutput("rst_retired", 32'(bus.retired), 32'h0);
    for (int i = 0; i < NL; i++) begin
      checkOutput($sformatf("rst_wdat%0d", i), bus.wdat[i*DW +: DW], 32'h0);
      checkOutput($sformatf("rst_wsel%0d", i), 32'(bus.wsel[i*RW +: RW]), 32'h0);
      checkOutput($sformatf("rst_instru%0d", i), bus.instru_next[i*DW +: DW], 32'h0);
    end
    RST = 1'b0;
    randomInputs(1'b0, 1'b0);
    tick();
    checkOutput("post_rst_hold_wen", 32'(bus.WEN), 32'h0);
    expRetired = '0;

    $display("[TB] table vectors");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k], k, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < NL; i++) expRetired = expRetired + CW'(vecs[k].lane[i].valid);
      checkVec(vecs[k], k);
    end

    $display("[TB] hold with wben low");
    for (int c = 0; c < 3; c++) begin
      randomInputs(1'b0, 1'b0);
      tick();
      checkVec(vecs[8], 8);
    end

    $display("[TB] flush together with wben");
    applyStimulus(vecs[5], 5, 1'b1, 1'b1);
    tick();
    checkOutput("flush_wen", 32'(bus.WEN), 32'h0);
    checkOutput("flush_fwd", 32'(bus.fwd_valid), 32'h0);
    checkOutput("flush_retired", 32'(bus.retired), 32'(expRetired));
    checkOutput("flush_instru", bus.instru_next[31:0] | bus.instru_next[63:32], 32'h0);

    $display("[TB] retire counter wrap");
    RST = 1'b1;
    bus.wben = 1'b0;
    bus.flush = 1'b0;
    tick();
    RST = 1'b0;
    checkOutput("wrap_rst_retired", 32'(bus.retired), 32'h0);
    tmp = vecs[0];
    for (int k = 0; k < 15; k++) begin
      applyStimulus(tmp, k, 1'b1, 1'b0);
      tick();
    end
    checkOutput("wrap_pre_retired", 32'(bus.retired), 32'd15);
    tmp = vecs[1];
    applyStimulus(tmp, 20, 1'b1, 1'b0);
    tick();
    checkOutput("wrap_retired", 32'(bus.retired), 32'd1);
    checkOutput("wrap_wen", 32'(bus.WEN), 32'h3);
    bus.wben = 1'b0;
    tick();
    checkOutput("wrap_hold_retired", 32'(bus.retired), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
